// File: rtl/agc_rupt_pkg.sv
// Shared state encoding and vector constants for the RUPT priority controller.
package agc_rupt_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, FORCE, SERVE} rupt_state_t;

  localparam logic [11:0] RUPT_VEC_BASE   = 12'o4004;
  localparam int          RUPT_VEC_STRIDE = 4;
  localparam int          RUPT_NRUPT_DEF  = 10;

endpackage

// File: rtl/rupt_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational, zero latency.
module rupt_prio_enc #(
  parameter int NRUPT = 10,
  parameter int IDXW  = 4
) (
  input  logic [NRUPT-1:0] req,
  output logic [IDXW-1:0]  idx,
  output logic             vld
);

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NRUPT - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDXW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rupt_priority_ctrl.sv
// RUPT request latch, arbiter and SQ force sequencer; requests pend one cycle after their rising edge.
// Define RUPT_LOCK_EN to build the SERVE / no-rupt lock alarm (RPTLOCK), otherwise RPTLOCK is tied low.
module rupt_priority_ctrl
  import agc_rupt_pkg::*;
#(
  parameter int NRUPT   = RUPT_NRUPT_DEF,
  parameter int IDXW    = 4,
  parameter int MAXWAIT = 16
`ifdef RUPT_LOCK_EN
  ,
  parameter int LOCK_LIMIT = 4096
`endif
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             GOJAM,
  input  logic [NRUPT-1:0] RPT_REQ,
  input  logic             T12,
  input  logic             NISQL,
  input  logic             INHINT,
  input  logic             OVNHRP,
  input  logic             MNHRPT,
  input  logic             RUPT_TAKEN,
  input  logic             RESUME,
  output logic             RUPTOR_n,
  output logic             RPTFRC,
  output logic             KRPT,
  output logic [IDXW-1:0]  RPT_IDX,
  output logic [11:0]      RPT_ADDR,
  output logic [NRUPT-1:0] PEND,
  output logic             IIP,
  output logic             RPT_TMO,
  output logic             RPTLOCK
);

  localparam int WAITW = $clog2(MAXWAIT + 1);

  rupt_state_t      state;
  logic [NRUPT-1:0] req_q;
  logic [NRUPT-1:0] req_rise;
  logic [NRUPT-1:0] krpt_clr;
  logic [NRUPT-1:0] pend_nxt;
  logic [WAITW-1:0] wait_cnt;
  logic [IDXW-1:0]  win_idx;
  logic             win_vld;
  logic             blocked;
  logic             grantable;

  rupt_prio_enc #(
    .NRUPT(NRUPT),
    .IDXW (IDXW)
  ) u_prio_enc (
    .req(PEND),
    .idx(win_idx),
    .vld(win_vld)
  );

  assign blocked   = INHINT | IIP | OVNHRP | MNHRPT;
  assign grantable = win_vld & ~blocked;
  assign RUPTOR_n  = ~grantable;
  assign RPT_ADDR  = RUPT_VEC_BASE + 12'(RPT_IDX) * 12'(RUPT_VEC_STRIDE);
  assign req_rise  = RPT_REQ & ~req_q;

  always_comb begin
    krpt_clr = '0;
    if (state == FORCE && RUPT_TAKEN) krpt_clr[RPT_IDX] = 1'b1;
  end

  // A fresh edge on the bit being served re-pends it rather than being lost.
  assign pend_nxt = (PEND & ~krpt_clr) | req_rise;

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state    <= IDLE;
      req_q    <= '0;
      PEND     <= '0;
      RPT_IDX  <= '0;
      wait_cnt <= '0;
      RPTFRC   <= 1'b0;
      KRPT     <= 1'b0;
      IIP      <= 1'b0;
      RPT_TMO  <= 1'b0;
    end else if (GOJAM) begin
      state    <= IDLE;
      req_q    <= '0;
      PEND     <= '0;
      RPT_IDX  <= '0;
      wait_cnt <= '0;
      RPTFRC   <= 1'b0;
      KRPT     <= 1'b0;
      IIP      <= 1'b0;
      RPT_TMO  <= 1'b0;
    end else begin
      KRPT    <= 1'b0;
      RPT_TMO <= 1'b0;
      req_q   <= RPT_REQ;
      PEND    <= pend_nxt;
      case (state)
        IDLE: begin
          if (grantable) begin
            state   <= ARMED;
            RPT_IDX <= win_idx;
          end
        end
        ARMED: begin
          if (!grantable) begin
            state <= IDLE;
          end else begin
            RPT_IDX <= win_idx;
            if (T12 && NISQL) begin
              state    <= FORCE;
              RPTFRC   <= 1'b1;
              wait_cnt <= '0;
            end
          end
        end
        FORCE: begin
          if (RUPT_TAKEN) begin
            state  <= SERVE;
            KRPT   <= 1'b1;
            IIP    <= 1'b1;
            RPTFRC <= 1'b0;
          end else if (wait_cnt == WAITW'(MAXWAIT - 1)) begin
            state   <= IDLE;
            RPT_TMO <= 1'b1;
            RPTFRC  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SERVE: begin
          if (RESUME) begin
            state <= IDLE;
            IIP   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RUPT_LOCK_EN
  localparam int LCKW = $clog2(LOCK_LIMIT + 1);
  localparam logic [LCKW-1:0] LOCK_MAX = LCKW'(LOCK_LIMIT);

  logic [LCKW-1:0] serve_cnt;
  logic [LCKW-1:0] quiet_cnt;

  // quiet_cnt holds through FORCE: only a real SERVE entry or INHINT restarts the no-rupt window.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      serve_cnt <= '0;
      quiet_cnt <= '0;
      RPTLOCK   <= 1'b0;
    end else if (GOJAM) begin
      serve_cnt <= '0;
      quiet_cnt <= '0;
      RPTLOCK   <= 1'b0;
    end else begin
      if (state == SERVE) begin
        if (serve_cnt != LOCK_MAX) serve_cnt <= serve_cnt + 1'b1;
      end else begin
        serve_cnt <= '0;
      end
      if (state == SERVE || INHINT) begin
        quiet_cnt <= '0;
      end else if ((state == IDLE || state == ARMED) && quiet_cnt != LOCK_MAX) begin
        quiet_cnt <= quiet_cnt + 1'b1;
      end
      if (serve_cnt == LOCK_MAX || quiet_cnt == LOCK_MAX) RPTLOCK <= 1'b1;
    end
  end
`else
  assign RPTLOCK = 1'b0;
`endif

endmodule

// File: tb/tb_rupt_priority_ctrl.sv
// Directed and random stimulus for rupt_priority_ctrl against a cycle-level reference model.
module tb_rupt_priority_ctrl;

  localparam int NR = 10;

  logic          SIM_CLK = 1'b0;
  logic          SIM_RST = 1'b0;
  logic          GOJAM = 1'b0, T12 = 1'b0, NISQL = 1'b0, INHINT = 1'b0;
  logic          OVNHRP = 1'b0, MNHRPT = 1'b0, RUPT_TAKEN = 1'b0, RESUME = 1'b0;
  logic [NR-1:0] RPT_REQ = '0;
  logic          RUPTOR_n, RPTFRC, KRPT, IIP, RPT_TMO, RPTLOCK;
  logic [3:0]    RPT_IDX;
  logic [11:0]   RPT_ADDR;
  logic [NR-1:0] PEND;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference model: pending set, serving phase flags, forced index, cycles spent forcing.
  logic [NR-1:0] m_pend, m_req_prev;
  bit            m_armed, m_forcing, m_serving, m_iip, m_krpt, m_tmo;
  int            m_idx, m_fcyc;

  rupt_priority_ctrl dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .GOJAM(GOJAM), .RPT_REQ(RPT_REQ),
    .T12(T12), .NISQL(NISQL), .INHINT(INHINT), .OVNHRP(OVNHRP), .MNHRPT(MNHRPT),
    .RUPT_TAKEN(RUPT_TAKEN), .RESUME(RESUME), .RUPTOR_n(RUPTOR_n), .RPTFRC(RPTFRC),
    .KRPT(KRPT), .RPT_IDX(RPT_IDX), .RPT_ADDR(RPT_ADDR), .PEND(PEND), .IIP(IIP),
    .RPT_TMO(RPT_TMO), .RPTLOCK(RPTLOCK)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  function automatic int lowest(logic [NR-1:0] p);
    for (int i = 0; i < NR; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_pend = '0; m_req_prev = '0;
    m_armed = 0; m_forcing = 0; m_serving = 0; m_iip = 0; m_krpt = 0; m_tmo = 0;
    m_idx = 0; m_fcyc = 0;
  endtask

  task automatic m_step();
    logic [NR-1:0] rise, nxt;
    int w;
    bit blk;
    if (!SIM_RST || GOJAM) begin
      m_reset();
      return;
    end
    rise = RPT_REQ & ~m_req_prev;
    nxt  = m_pend;
    w    = lowest(m_pend);
    blk  = INHINT | m_iip | OVNHRP | MNHRPT;
    m_krpt = 0;
    m_tmo  = 0;
    if (m_forcing) begin
      m_fcyc++;
      if (RUPT_TAKEN) begin
        nxt[m_idx] = 1'b0;
        m_krpt = 1; m_iip = 1; m_forcing = 0; m_serving = 1;
      end else if (m_fcyc == 16) begin
        m_tmo = 1; m_forcing = 0;
      end
    end else if (m_serving) begin
      if (RESUME) begin m_serving = 0; m_iip = 0; end
    end else if (w < 0 || blk) begin
      m_armed = 0;
    end else begin
      if (m_armed && T12 && NISQL) begin
        m_forcing = 1; m_armed = 0; m_fcyc = 0;
      end else begin
        m_armed = 1;
      end
      m_idx = w;
    end
    m_pend = nxt | rise;
    m_req_prev = RPT_REQ;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    bit blk;
    blk = INHINT | m_iip | OVNHRP | MNHRPT;
    chk("RPTFRC", 32'(RPTFRC), 32'(m_forcing));
    chk("KRPT", 32'(KRPT), 32'(m_krpt));
    chk("IIP", 32'(IIP), 32'(m_iip));
    chk("RPT_TMO", 32'(RPT_TMO), 32'(m_tmo));
    chk("PEND", 32'(PEND), 32'(m_pend));
    chk("RPT_IDX", 32'(RPT_IDX), 32'(m_idx));
    chk("RPT_ADDR", 32'(RPT_ADDR), 32'h804 + 32'(4 * m_idx));
    chk("RUPTOR_n", 32'(RUPTOR_n), 32'(!((m_pend != '0) && !blk)));
`ifndef RUPT_LOCK_EN
    chk("RPTLOCK", 32'(RPTLOCK), 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge SIM_CLK);
    m_step();
    #1;
    chk_all();
  endtask

  task automatic boundary();
    T12 = 1'b1; NISQL = 1'b1;
    tick();
    T12 = 1'b0; NISQL = 1'b0;
  endtask

  task automatic pulse_taken();
    RUPT_TAKEN = 1'b1;
    tick();
    RUPT_TAKEN = 1'b0;
  endtask

  task automatic pulse_resume();
    RESUME = 1'b1;
    tick();
    RESUME = 1'b0;
  endtask

  initial begin
    m_reset();
    #12;
    chk("rst RUPTOR_n", 32'(RUPTOR_n), 32'd1);
    chk("rst RPTFRC", 32'(RPTFRC), 32'd0);
    chk("rst PEND", 32'(PEND), 32'd0);
    chk("rst IDX", 32'(RPT_IDX), 32'd0);
    chk_all();
    SIM_RST = 1'b1;

    // single request on index 2
    RPT_REQ[2] = 1'b1;
    tick();
    chk("single RUPTOR_n", 32'(RUPTOR_n), 32'd0);
    tick();
    boundary();
    chk("single RPTFRC", 32'(RPTFRC), 32'd1);
    chk("single IDX", 32'(RPT_IDX), 32'd2);
    chk("single ADDR", 32'(RPT_ADDR), 32'(12'o4014));
    pulse_taken();
    chk("single KRPT", 32'(KRPT), 32'd1);
    chk("single PEND2", 32'(PEND[2]), 32'd0);
    chk("single IIP", 32'(IIP), 32'd1);
    tick();
    chk("single KRPT one-shot", 32'(KRPT), 32'd0);
    pulse_resume();
    chk("single IIP clear", 32'(IIP), 32'd0);
    RPT_REQ = '0;
    tick();

    // priority: index 1 arrives while index 5 is armed
    RPT_REQ[5] = 1'b1;
    tick(); tick();
    RPT_REQ[1] = 1'b1;
    tick(); tick();
    boundary();
    chk("prio IDX", 32'(RPT_IDX), 32'd1);
    chk("prio PEND5", 32'(PEND[5]), 32'd1);
    pulse_taken();
    pulse_resume();
    tick();
    boundary();
    chk("prio second IDX", 32'(RPT_IDX), 32'd5);
    chk("prio second ADDR", 32'(RPT_ADDR), 32'(12'o4030));
    pulse_taken();
    pulse_resume();
    RPT_REQ = '0;
    tick();

    // blocking by INHINT
    INHINT = 1'b1;
    RPT_REQ[0] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      boundary();
      chk("block RUPTOR_n", 32'(RUPTOR_n), 32'd1);
      chk("block RPTFRC", 32'(RPTFRC), 32'd0);
      tick();
    end
    INHINT = 1'b0;
    tick();
    boundary();
    chk("unblock RPTFRC", 32'(RPTFRC), 32'd1);

    // timeout: no RUPT_TAKEN for 16 cycles
    repeat (15) tick();
    chk("tmo early", 32'(RPT_TMO), 32'd0);
    tick();
    chk("tmo pulse", 32'(RPT_TMO), 32'd1);
    chk("tmo RPTFRC", 32'(RPTFRC), 32'd0);
    chk("tmo PEND0", 32'(PEND[0]), 32'd1);
    tick();
    chk("tmo one-shot", 32'(RPT_TMO), 32'd0);
    boundary();
    chk("tmo rearm", 32'(RPTFRC), 32'd1);
    pulse_taken();
    pulse_resume();
    RPT_REQ = '0;
    tick();

    // new edge on bit 3 in the same cycle it is cleared
    RPT_REQ[3] = 1'b1;
    tick();
    RPT_REQ[3] = 1'b0;
    tick();
    boundary();
    RPT_REQ[3] = 1'b1;
    pulse_taken();
    chk("setclr KRPT", 32'(KRPT), 32'd1);
    chk("setclr PEND3", 32'(PEND[3]), 32'd1);

    // GOJAM while serving with two requests pending
    RPT_REQ = '0;
    GOJAM = 1'b1;
    tick();
    GOJAM = 1'b0;
    RPT_REQ = 10'b0000010100;
    tick(); tick();
    boundary();
    pulse_taken();
    RPT_REQ[1] = 1'b1;
    tick();
    chk("gojam pre PEND", 32'(PEND), 32'h012);
    GOJAM = 1'b1;
    tick();
    GOJAM = 1'b0;
    chk("gojam PEND", 32'(PEND), 32'd0);
    chk("gojam IIP", 32'(IIP), 32'd0);
    chk("gojam RUPTOR_n", 32'(RUPTOR_n), 32'd1);
    chk("gojam IDX", 32'(RPT_IDX), 32'd0);
    pulse_resume();

    // asynchronous reset while forcing
    RPT_REQ = '0;
    tick();
    boundary();
    chk("arst pre RPTFRC", 32'(RPTFRC), 32'd1);
    #3 SIM_RST = 1'b0;
    #1 chk("arst RPTFRC", 32'(RPTFRC), 32'd0);
    chk("arst PEND", 32'(PEND), 32'd0);
    m_reset();
    #1 SIM_RST = 1'b1;

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) RPT_REQ = NR'($urandom);
      INHINT     = ($urandom_range(0, 7) == 0);
      OVNHRP     = ($urandom_range(0, 15) == 0);
      MNHRPT     = ($urandom_range(0, 15) == 0);
      T12        = ($urandom_range(0, 1) == 0);
      NISQL      = ($urandom_range(0, 1) == 0);
      RUPT_TAKEN = ($urandom_range(0, 11) == 0);
      RESUME     = ($urandom_range(0, 5) == 0);
      GOJAM      = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
